// File: rtl/hdmi_mode_sequencer.sv
// Mode/pattern change sequencer: latches host requests, applies them atomically to the
// sync and pattern blocks on a frame boundary, then waits SETTLE_FRAMES before reporting stable.
module hdmi_mode_sequencer #(
    parameter int widthAddr     = 12,
    parameter int heightAddr    = 12,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  setMode__ENA,
    input  logic [1:0]            setMode_mode,
    output logic                  setMode__RDY,
    input  logic                  setPattern__ENA,
    input  logic [7:0]            setPattern_pattern,
    input  logic [19:0]           setPattern_rampStep,
    output logic                  setPattern__RDY,
    input  logic                  vSync,
    output logic                  sync_setup__ENA,
    output logic [widthAddr-1:0]  sync_setup_ahEnd,
    output logic [widthAddr-1:0]  sync_setup_ahFrontEnd,
    output logic [widthAddr-1:0]  sync_setup_ahBackSync,
    output logic [widthAddr-1:0]  sync_setup_ahSyncWidth,
    output logic [heightAddr-1:0] sync_setup_avEnd,
    output logic [heightAddr-1:0] sync_setup_avFrontEnd,
    output logic [heightAddr-1:0] sync_setup_avBackSync,
    output logic [heightAddr-1:0] sync_setup_avSyncWidth,
    input  logic                  sync_setup__RDY,
    output logic                  pattern_setup__ENA,
    output logic [widthAddr-1:0]  pattern_setup_aactivePixels,
    output logic [heightAddr-1:0] pattern_setup_aactiveLines,
    output logic [7:0]            pattern_setup_apattern,
    output logic [19:0]           pattern_setup_arampStep,
    input  logic                  pattern_setup__RDY,
    output logic                  running,
    output logic [1:0]            modeActive,
    output logic                  badMode
);

    typedef enum logic [1:0] {UNCONF, APPLY, SETTLE, RUN} state_t;

    typedef struct packed {
        logic [widthAddr-1:0]  hEnd, hFront, hBack, hSw;
        logic [heightAddr-1:0] vEnd, vFront, vBack, vSw;
    } timing_t;

    function automatic timing_t f_timing(input logic [1:0] m);
        timing_t t;
        t.hEnd = widthAddr'(2200);  t.hFront = widthAddr'(1920);
        t.hBack = widthAddr'(2008); t.hSw = widthAddr'(44);
        t.vEnd = heightAddr'(1125); t.vFront = heightAddr'(1080);
        t.vBack = heightAddr'(1084); t.vSw = heightAddr'(5);
        case (m)
            2'd1: begin
                t.hEnd = widthAddr'(1650);  t.hFront = widthAddr'(1280);
                t.hBack = widthAddr'(1390); t.hSw = widthAddr'(40);
                t.vEnd = heightAddr'(750);  t.vFront = heightAddr'(720);
                t.vBack = heightAddr'(725); t.vSw = heightAddr'(5);
            end
            2'd2: begin
                t.hEnd = widthAddr'(858);   t.hFront = widthAddr'(720);
                t.hBack = widthAddr'(736);  t.hSw = widthAddr'(62);
                t.vEnd = heightAddr'(525);  t.vFront = heightAddr'(480);
                t.vBack = heightAddr'(489); t.vSw = heightAddr'(6);
            end
            default: ;
        endcase
        return t;
    endfunction

    state_t      r_state, w_next;
    logic        r_vsync_d;
    logic [1:0]  r_mode_pend, r_mode_active;
    logic        r_mode_pflag, r_pat_pflag;
    logic [7:0]  r_pat_pend, r_pat_app;
    logic [19:0] r_ramp_pend, r_ramp_app;
    logic        r_bad, r_running, w_run_next;
    logic [3:0]  r_settle_cnt, w_cnt_next;

    logic        w_rise, w_any, w_rdy, w_fire, w_apply, w_zero;
    logic [1:0]  w_mode_sel;
    logic [7:0]  w_pat_sel;
    logic [19:0] w_ramp_sel;
    timing_t     w_tim;

    assign w_rise  = vSync && !r_vsync_d;
    assign w_any   = r_mode_pflag || r_pat_pflag;
    assign w_apply = (r_state == APPLY);
    assign w_rdy   = !w_apply;
    assign w_fire  = w_apply && sync_setup__RDY && pattern_setup__RDY;
    assign w_zero  = (r_state == UNCONF);

    // In APPLY the outputs preview the pending change; otherwise they hold what was applied.
    assign w_mode_sel = r_mode_pflag ? r_mode_pend : r_mode_active;
    assign w_pat_sel  = (w_apply && r_pat_pflag) ? r_pat_pend  : r_pat_app;
    assign w_ramp_sel = (w_apply && r_pat_pflag) ? r_ramp_pend : r_ramp_app;
    assign w_tim      = f_timing(w_apply ? w_mode_sel : r_mode_active);

    assign setMode__RDY    = w_rdy;
    assign setPattern__RDY = w_rdy;
    assign sync_setup__ENA    = w_fire;
    assign pattern_setup__ENA = w_fire;

    assign sync_setup_ahEnd       = w_zero ? '0 : w_tim.hEnd;
    assign sync_setup_ahFrontEnd  = w_zero ? '0 : w_tim.hFront;
    assign sync_setup_ahBackSync  = w_zero ? '0 : w_tim.hBack;
    assign sync_setup_ahSyncWidth = w_zero ? '0 : w_tim.hSw;
    assign sync_setup_avEnd       = w_zero ? '0 : w_tim.vEnd;
    assign sync_setup_avFrontEnd  = w_zero ? '0 : w_tim.vFront;
    assign sync_setup_avBackSync  = w_zero ? '0 : w_tim.vBack;
    assign sync_setup_avSyncWidth = w_zero ? '0 : w_tim.vSw;
    assign pattern_setup_aactivePixels = w_zero ? '0 : w_tim.hFront;
    assign pattern_setup_aactiveLines  = w_zero ? '0 : w_tim.vFront;
    assign pattern_setup_apattern      = w_zero ? '0 : w_pat_sel;
    assign pattern_setup_arampStep     = w_zero ? '0 : w_ramp_sel;

    assign running    = r_running;
    assign modeActive = r_mode_active;
    assign badMode    = r_bad;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_settle_cnt;
        w_run_next = r_running;
        case (r_state)
            UNCONF: if (w_any) w_next = APPLY;
            APPLY: if (w_fire) begin
                w_next     = SETTLE;
                w_cnt_next = '0;
                w_run_next = 1'b0;
            end
            SETTLE: if (w_rise) begin
                if (w_any) begin
                    w_next = APPLY;
                end else if (r_settle_cnt == 4'(SETTLE_FRAMES - 1)) begin
                    w_next     = RUN;
                    w_run_next = 1'b1;
                end else begin
                    w_cnt_next = r_settle_cnt + 4'd1;
                end
            end
            RUN: if (w_rise && w_any) w_next = APPLY;
            default: w_next = UNCONF;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= UNCONF;
            r_settle_cnt <= '0;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_settle_cnt <= w_cnt_next;
            r_running    <= w_run_next;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_vsync_d     <= 1'b0;
            r_mode_pend   <= '0;
            r_mode_pflag  <= 1'b0;
            r_mode_active <= '0;
            r_pat_pend    <= '0;
            r_ramp_pend   <= '0;
            r_pat_pflag   <= 1'b0;
            r_pat_app     <= '0;
            r_ramp_app    <= '0;
            r_bad         <= 1'b0;
        end else begin
            r_vsync_d <= vSync;
            if (w_fire) begin
                r_mode_pflag  <= 1'b0;
                r_pat_pflag   <= 1'b0;
                r_mode_active <= w_mode_sel;
                if (r_pat_pflag) begin
                    r_pat_app  <= r_pat_pend;
                    r_ramp_app <= r_ramp_pend;
                end
            end
            // Requests cannot be accepted while firing, so these never collide with the clears above.
            if (setMode__ENA && w_rdy) begin
                if (setMode_mode == 2'd3) begin
                    r_bad <= 1'b1;
                end else begin
                    r_mode_pend  <= setMode_mode;
                    r_mode_pflag <= 1'b1;
                end
            end
            if (setPattern__ENA && w_rdy) begin
                r_pat_pend  <= setPattern_pattern;
                r_ramp_pend <= setPattern_rampStep;
                r_pat_pflag <= 1'b1;
            end
        end
    end

endmodule
